// File: rtl/huff_pkg.sv
// huff_pkg
//   Shared definitions for the Huffman encoder control unit and the
//   Huffman bitstream decoder: table geometry, symbol width and the
//   IDLE/RUN/ERR state encoding.
//   len_mask(len) returns a mask of 'len' contiguous ones from the LSB.
//   The decoder compares each table mask against this value to check
//   the code length of a table entry.
package huff_pkg;

   localparam int NSYM   = 6;                  // symbols / table entries
   localparam int CODE_W = 8;                  // max code length, entry width
   localparam int SYM_W  = 3;                  // symbol output width
   localparam int LEN_W  = $clog2(CODE_W + 1); // holds 0..CODE_W
   localparam int CNT_W  = 8;                  // per-symbol counter width

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      ERR  = 2'd2
   } state_t;

   function automatic logic [CODE_W-1:0] len_mask(input logic [LEN_W-1:0] len);
      logic [CODE_W-1:0] m;
      for (int i = 0; i < CODE_W; i++) begin
         m[i] = (i < int'(len));
      end
      return m;
   endfunction

endpackage

// File: rtl/huff_match.sv
// huff_match
//   Combinational prefix matcher. It checks the candidate code (shift
//   register after the new bit, and its length) against every table entry.
//   Ports:
//     sr_n    in  CODE_W       candidate code bits, LSB = newest bit
//     len_n   in  LEN_W        number of valid bits in sr_n
//     hc_flat in  NSYM*CODE_W  code table, entry i at [i*CODE_W +: CODE_W]
//     m_flat  in  NSYM*CODE_W  mask table, same layout
//     hit     out 1            some entry matches
//     idx     out SYM_W        index of the matching entry (lowest index wins)
module huff_match
   import huff_pkg::*;
(
   input  logic [CODE_W-1:0]      sr_n,
   input  logic [LEN_W-1:0]       len_n,
   input  logic [NSYM*CODE_W-1:0] hc_flat,
   input  logic [NSYM*CODE_W-1:0] m_flat,
   output logic                   hit,
   output logic [SYM_W-1:0]       idx
);

   logic [CODE_W-1:0] lm;

   always_comb begin
      lm  = len_mask(len_n);
      hit = 1'b0;
      idx = '0;
      // Scan from the top index down so the lowest matching index is
      // assigned last. An all-zero mask is an unused entry and never hits.
      for (int i = NSYM - 1; i >= 0; i--) begin
         if ((m_flat[i*CODE_W +: CODE_W] != '0) &&
             (m_flat[i*CODE_W +: CODE_W] == lm) &&
             ((sr_n & m_flat[i*CODE_W +: CODE_W]) == hc_flat[i*CODE_W +: CODE_W])) begin
            hit = 1'b1;
            idx = SYM_W'(i);
         end
      end
   end

endmodule

// File: rtl/huff_decoder.sv
// huff_decoder
//   Decodes a serial Huffman bitstream into 3-bit gray-level symbols 1..6
//   using the HC/M table that the encoder publishes with code_valid.
//   Optional feature macro: HUFF_DEC_CNT_EN adds saturating per-symbol
//   decode counters. Without it, cnt_flat is tied to 0.
//   Handshake: a bit is consumed on each rising clk edge where the state is
//   RUN (ready=1), bit_valid=1 and code_valid=0. There is no backpressure
//   beyond ready. sym_valid pulses for one cycle, one cycle after the bit
//   that completes a code.
//   Ports:
//     clk, reset  clock (rising edge), asynchronous active-high reset
//     code_valid  load hc_flat/m_flat, clear partial code and err, enter RUN
//     hc_flat     code table (LSB-aligned codes)
//     m_flat      mask table (contiguous ones from LSB = code length)
//     bit_in      stream bit; first bit of a code is its MSB
//     bit_valid   bit_in valid this cycle
//     ready       table loaded and no error
//     sym_out     last decoded symbol (index+1), held between hits
//     sym_valid   one-cycle pulse per decoded symbol
//     err         sticky: CODE_W bits taken without a match
//     cnt_flat    per-symbol 8-bit decode counts, entry i = symbol i+1
module huff_decoder
   import huff_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   code_valid,
   input  logic [NSYM*CODE_W-1:0] hc_flat,
   input  logic [NSYM*CODE_W-1:0] m_flat,
   input  logic                   bit_in,
   input  logic                   bit_valid,
   output logic                   ready,
   output logic [SYM_W-1:0]       sym_out,
   output logic                   sym_valid,
   output logic                   err,
   output logic [NSYM*CNT_W-1:0]  cnt_flat
);

   state_t                 state, state_d;
   logic [NSYM*CODE_W-1:0] hc_q, hc_d;
   logic [NSYM*CODE_W-1:0] m_q, m_d;
   logic [CODE_W-1:0]      sr, sr_d, sr_n;
   logic [LEN_W-1:0]       len, len_d, len_n;
   logic [SYM_W-1:0]       sym_out_d;
   logic                   sym_valid_d, err_d, ready_d;
   logic                   accept, hit;
   logic [SYM_W-1:0]       idx;

   // Candidate code formed by the incoming bit; matched before it is stored.
   assign sr_n   = {sr[CODE_W-2:0], bit_in};
   assign len_n  = len + LEN_W'(1);
   // A bit arriving together with a table load is dropped.
   assign accept = (state == RUN) && bit_valid && !code_valid;

   huff_match u_match (
      .sr_n    (sr_n),
      .len_n   (len_n),
      .hc_flat (hc_q),
      .m_flat  (m_q),
      .hit     (hit),
      .idx     (idx)
   );

   always_comb begin
      state_d     = state;
      hc_d        = hc_q;
      m_d         = m_q;
      sr_d        = sr;
      len_d       = len;
      sym_out_d   = sym_out;
      sym_valid_d = 1'b0;
      err_d       = err;
      if (code_valid) begin
         hc_d    = hc_flat;
         m_d     = m_flat;
         sr_d    = '0;
         len_d   = '0;
         err_d   = 1'b0;
         state_d = RUN;
      end else if (accept) begin
         if (hit) begin
            sym_valid_d = 1'b1;
            sym_out_d   = idx + SYM_W'(1);
            sr_d        = '0;
            len_d       = '0;
         end else if (len_n == LEN_W'(CODE_W)) begin
            err_d   = 1'b1;
            state_d = ERR;
            sr_d    = '0;
            len_d   = '0;
         end else begin
            sr_d  = sr_n;
            len_d = len_n;
         end
      end
      ready_d = (state_d == RUN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         hc_q      <= '0;
         m_q       <= '0;
         sr        <= '0;
         len       <= '0;
         sym_out   <= '0;
         sym_valid <= 1'b0;
         err       <= 1'b0;
         ready     <= 1'b0;
      end else begin
         state     <= state_d;
         hc_q      <= hc_d;
         m_q       <= m_d;
         sr        <= sr_d;
         len       <= len_d;
         sym_out   <= sym_out_d;
         sym_valid <= sym_valid_d;
         err       <= err_d;
         ready     <= ready_d;
      end
   end

`ifdef HUFF_DEC_CNT_EN
   logic [NSYM-1:0][CNT_W-1:0] cnt_q;

   // Counted on the hit edge so each count is updated when its sym_valid
   // pulse appears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (code_valid) begin
         cnt_q <= '0;
      end else if (accept && hit) begin
         for (int i = 0; i < NSYM; i++) begin
            if ((SYM_W'(i) == idx) && (cnt_q[i] != {CNT_W{1'b1}})) begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   assign cnt_flat = cnt_q;
`else
   assign cnt_flat = '0;
`endif

endmodule

// File: tb/tb_huff_decoder.sv
// tb_huff_decoder
//   Directed bench for huff_decoder. The drivers push {expected cycle,
//   expected symbol} into exp_q when they issue the last bit of a code.
//   The monitor pops one entry for each sym_valid pulse and checks the
//   symbol and the exact cycle. An unexpected pulse counts as an error.
module tb_huff_decoder;
   import huff_pkg::*;

   localparam logic [NSYM*CODE_W-1:0] T_HC  = 48'h1F1E0E060200;
   localparam logic [NSYM*CODE_W-1:0] T_M   = 48'h1F1F0F070301;
   localparam logic [NSYM*CODE_W-1:0] S1_HC = 48'h000000000000;
   localparam logic [NSYM*CODE_W-1:0] S1_M  = 48'h000000000001;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   code_valid;
   logic [NSYM*CODE_W-1:0] hc_flat;
   logic [NSYM*CODE_W-1:0] m_flat;
   logic                   bit_in;
   logic                   bit_valid;
   logic                   ready;
   logic [SYM_W-1:0]       sym_out;
   logic                   sym_valid;
   logic                   err;
   logic [NSYM*CNT_W-1:0]  cnt_flat;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic [34:0] exp_q[$];   // {cycle[31:0], symbol[2:0]}

   huff_decoder dut (
      .clk        (clk),
      .reset      (reset),
      .code_valid (code_valid),
      .hc_flat    (hc_flat),
      .m_flat     (m_flat),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .ready      (ready),
      .sym_out    (sym_out),
      .sym_valid  (sym_valid),
      .err        (err),
      .cnt_flat   (cnt_flat)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called #1 after a rising edge. Holds the inputs for one edge.
   task automatic drive(input logic cv, input logic bv, input logic b,
                        input logic [2:0] sym, input logic push);
      logic [31:0] due;
      code_valid = cv;
      bit_valid  = bv;
      bit_in     = b;
      due        = cyc + 1;
      if (push) exp_q.push_back({due, sym});
      @(posedge clk);
      #1;
      code_valid = 1'b0;
      bit_valid  = 1'b0;
      bit_in     = 1'b0;
   endtask

   task automatic load(input logic [NSYM*CODE_W-1:0] hc, input logic [NSYM*CODE_W-1:0] m);
      hc_flat = hc;
      m_flat  = m;
      drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
   endtask

   task automatic send(input logic b);
      drive(1'b0, 1'b1, b, 3'd0, 1'b0);
   endtask

   task automatic send_last(input logic b, input logic [2:0] sym);
      drive(1'b0, 1'b1, b, sym, 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
      check("drain_pending", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (sym_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_sym: sym_out=%0d at cycle %0d, none expected", sym_out, cyc);
         end else begin
            logic [34:0] e;
            e = exp_q.pop_front();
            if (sym_out !== e[2:0] || cyc != int'(e[34:3])) begin
               errors++;
               $display("FAIL sym: got sym %0d at cycle %0d, expected sym %0d at cycle %0d",
                        sym_out, cyc, e[2:0], e[34:3]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset      = 1'b1;
      code_valid = 1'b0;
      hc_flat    = '0;
      m_flat     = '0;
      bit_in     = 1'b0;
      bit_valid  = 1'b0;
      #12;
      check("reset_ready", 64'(ready), 64'd0);
      check("reset_sym_out", 64'(sym_out), 64'd0);
      check("reset_sym_valid", 64'(sym_valid), 64'd0);
      check("reset_err", 64'(err), 64'd0);
      check("reset_cnt", 64'(cnt_flat), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Bits with no table loaded are ignored.
      send(1'b0); send(1'b0); send(1'b1);
      idle(2);
      check("notable_ready", 64'(ready), 64'd0);
      check("notable_sym_out", 64'(sym_out), 64'd0);
      check("notable_err", 64'(err), 64'd0);

      // Back-to-back codes: 0 | 10 | 11111 -> 1, 2, 6
      load(T_HC, T_M);
      check("load_ready", 64'(ready), 64'd1);
      check("load_err", 64'(err), 64'd0);
      send_last(1'b0, 3'd1);
      send(1'b1); send_last(1'b0, 3'd2);
      send(1'b1); send(1'b1); send(1'b1); send(1'b1); send_last(1'b1, 3'd6);
      drain();
      idle(3);
      check("hold_sym_out", 64'(sym_out), 64'd6);
      check("run_ready", 64'(ready), 64'd1);

      // Gaps between bits: 1 . . . 1 . . . 0 -> 3
      load(T_HC, T_M);
      send(1'b1); idle(3);
      send(1'b1); idle(3);
      send_last(1'b0, 3'd3);
      drain();

      // Table with only s1: eight 1s overflow into ERR.
      load(S1_HC, S1_M);
      repeat (7) send(1'b1);
      check("pre_ovf_err", 64'(err), 64'd0);
      check("pre_ovf_ready", 64'(ready), 64'd1);
      send(1'b1);
      check("ovf_err", 64'(err), 64'd1);
      check("ovf_ready", 64'(ready), 64'd0);
      send(1'b0);
      idle(2);
      check("err_sticky", 64'(err), 64'd1);
      check("err_ready", 64'(ready), 64'd0);
      load(T_HC, T_M);
      check("reload_err", 64'(err), 64'd0);
      check("reload_ready", 64'(ready), 64'd1);

      // Partial code 11 and a same-cycle bit dropped by a reload; next 0 -> 1
      load(T_HC, T_M);
      send(1'b1); send(1'b1);
      drive(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
      send_last(1'b0, 3'd1);
      drain();
      check("partial_sym_out", 64'(sym_out), 64'd1);

      // 300 symbol-1 codes: the counter saturates when counting is built in.
      load(T_HC, T_M);
      check("cnt_after_load", 64'(cnt_flat), 64'd0);
      repeat (300) send_last(1'b0, 3'd1);
      drain();
`ifdef HUFF_DEC_CNT_EN
      check("cnt_saturated", 64'(cnt_flat), 64'h0000000000FF);
`else
      check("cnt_disabled", 64'(cnt_flat), 64'd0);
`endif

      // Asynchronous reset in the middle of a code discards everything.
      send(1'b1); send(1'b1);
      reset = 1'b1;
      #2;
      check("midrst_cnt", 64'(cnt_flat), 64'd0);
      check("midrst_ready", 64'(ready), 64'd0);
      check("midrst_sym_out", 64'(sym_out), 64'd0);
      check("midrst_err", 64'(err), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      send(1'b0); send(1'b0);
      idle(2);
      check("postrst_ready", 64'(ready), 64'd0);
      check("postrst_sym_out", 64'(sym_out), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
